shl_lane_seq: RTL and testbench

//  Sequencer directly upstream of the combinational 96-bit lane shifter (8 lanes x 12 bits).
//  The shifter moves by 0..5 lanes per pass; this block accepts left shifts of 0..8 lanes per word.
//  It feeds the shifter one step per cycle, registers each result and loops it back until done.
//  It then presents the finished word downstream with a valid/ready handshake.

---
 rtl/shl_pkg.sv | 17 +
 rtl/shl_step_sel.sv | 25 ++
 rtl/shl_lane_seq.sv | 142 ++++++++++++++
 tb/tb_shl_lane_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shl_pkg.sv
// Shared constants and types for the lane-shift sequencer and its step selector.
package shl_pkg;

  localparam int LANE_W   = 12;
  localparam int LANES    = 8;
  localparam int DATA_W   = LANES * LANE_W;
  localparam int MAX_STEP = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } shl_seq_state_t;

  typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/shl_step_sel.sv
// Picks the lane step for the next shifter pass and the lanes left after it.
module shl_step_sel
  import shl_pkg::*;
(
  input  logic [3:0] rem,
  output logic [2:0] step,
  output logic [3:0] rem_next,
  output logic       last
);

  // NOTE: every output gets a value on every path so no latch is inferred.
  always_comb begin
    step     = 3'd0;
    rem_next = 4'd0;
    last     = 1'b0;
    if (rem > 4'(MAX_STEP)) begin
      step = 3'(MAX_STEP);
    end else begin
      step = rem[2:0];
    end
    rem_next = rem - {1'b0, step};
    last     = (rem_next == 4'd0);
  end

endmodule

// File: rtl/shl_lane_seq.sv
// Left-shift sequencer: splits a 0..8 lane shift into passes of at most MAX_STEP lanes.
// Optional SHL_SEQ_ERRCHK_EN: honour shl_out_valid and flag an illegal step via out_err.
module shl_lane_seq
  import shl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_lanes,
  input  logic [LANE_W-1:0] in_fill,
  output logic [DATA_W-1:0] shl_in,
  output logic [2:0]        shl_shift,
  output logic [LANE_W-1:0] shl_fill,
  input  logic [DATA_W-1:0] shl_out,
  input  logic              shl_out_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_passes,
  output logic              out_sat,
  output logic              out_err
);

  shl_seq_state_t    state;
  logic [DATA_W-1:0] acc;
  lane_t             fill;
  logic [3:0]        rem;
  logic [1:0]        passes;
  logic              sat;

  logic [2:0] step;
  logic [3:0] rem_next;
  logic       last;
  logic       step_bad;
  logic       accept;
  logic [3:0] lanes_clamped;

  shl_step_sel u_step_sel (
    .rem      (rem),
    .step     (step),
    .rem_next (rem_next),
    .last     (last)
  );

  assign accept        = (state == IDLE) && in_ready && in_valid;
  assign lanes_clamped = (in_lanes > 4'(LANES)) ? 4'(LANES) : in_lanes;

  assign shl_in     = acc;
  assign shl_fill   = fill;
  assign shl_shift  = (state == STEP) ? step : 3'd0;
  assign out_data   = acc;
  assign out_passes = passes;
  assign out_sat    = sat;

`ifdef SHL_SEQ_ERRCHK_EN
  logic err;

  assign step_bad = !shl_out_valid;
  assign out_err  = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if ((state == STEP) && step_bad) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_shl_out_valid;

  assign unused_shl_out_valid = shl_out_valid;
  assign step_bad             = 1'b0;
  assign out_err              = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      fill      <= '0;
      rem       <= '0;
      passes    <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= in_data;
            fill     <= in_fill;
            rem      <= lanes_clamped;
            sat      <= (in_lanes > 4'(LANES));
            passes   <= 2'd0;
            in_ready <= 1'b0;
            if (lanes_clamped == 4'd0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= STEP;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        STEP: begin
          // An illegal step leaves the word as it stood before this pass.
          if (step_bad) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            acc    <= shl_out;
            rem    <= rem_next;
            passes <= passes + 2'd1;
            if (last) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shl_lane_seq.sv
// Bench for shl_lane_seq with a behavioural lane shifter; define SHL_SEQ_ERRCHK_EN to cover out_err.
module tb_shl_lane_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [95:0] in_data = '0;
  logic [3:0]  in_lanes = '0;
  logic [11:0] in_fill = '0;
  logic [95:0] shl_in;
  logic [2:0]  shl_shift;
  logic [11:0] shl_fill;
  logic [95:0] shl_out;
  logic        shl_out_valid;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] out_data;
  logic [1:0]  out_passes;
  logic        out_sat;
  logic        out_err;
  logic        force_bad = 1'b0;

  int errors = 0;
  int checks = 0;

  // Observations from the most recent transaction.
  logic [95:0] obs_data;
  int          obs_passes;
  logic        obs_sat;
  logic        obs_err;
  int          obs_lat;
  int          obs_steps;
  bit          obs_timeout;
  bit          obs_stable;
  logic        obs_ready_after;
  logic        obs_valid_after;

  always #5 clk = ~clk;

  shl_lane_seq dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_lanes      (in_lanes),
    .in_fill       (in_fill),
    .shl_in        (shl_in),
    .shl_shift     (shl_shift),
    .shl_fill      (shl_fill),
    .shl_out       (shl_out),
    .shl_out_valid (shl_out_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_passes    (out_passes),
    .out_sat       (out_sat),
    .out_err       (out_err)
  );

  // Stand-in for the parent's combinational lane shifter.
  always_comb begin
    shl_out = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(shl_shift)) shl_out[i*12 +: 12] = shl_in[(i - int'(shl_shift))*12 +: 12];
      else                      shl_out[i*12 +: 12] = shl_fill;
    end
    shl_out_valid = (shl_shift <= 3'd5) && !force_bad;
  end

  function automatic logic [95:0] ref_shift(input logic [95:0] d, input int n, input logic [11:0] f);
    logic [95:0] r;
    for (int i = 0; i < 8; i++) begin
      if (i >= n) r[i*12 +: 12] = d[(i - n)*12 +: 12];
      else        r[i*12 +: 12] = f;
    end
    return r;
  endfunction

  function automatic int ref_lanes(input logic [3:0] l);
    return (l > 4'd8) ? 8 : int'(l);
  endfunction

  function automatic int ref_passes(input int n);
    return (n == 0) ? 0 : ((n <= 5) ? 1 : 2);
  endfunction

  // Sequence of shifter steps, one hex digit per pass, first pass most significant.
  function automatic int ref_steps(input int n);
    return (n == 0) ? 0 : ((n <= 5) ? n : (5 * 16 + (n - 5)));
  endfunction

  task automatic run_word(input logic [95:0] d, input logic [3:0] l, input logic [11:0] f, input int hold);
    int n = 0;
    logic [95:0] cap;
    obs_timeout = 1'b0;
    obs_stable  = 1'b1;
    obs_steps   = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) obs_timeout = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_lanes  = l;
    in_fill   = f;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    obs_lat = 1;
    @(negedge clk);
    while (!out_valid && obs_lat < 20) begin
      if (shl_shift != 3'd0) obs_steps = obs_steps * 16 + int'(shl_shift);
      @(negedge clk);
      obs_lat++;
    end
    if (!out_valid) obs_timeout = 1'b1;
    obs_data   = out_data;
    obs_passes = int'(out_passes);
    obs_sat    = out_sat;
    obs_err    = out_err;
    cap        = out_data;
    repeat (hold) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== cap || in_ready !== 1'b0) obs_stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    obs_ready_after = in_ready;
    obs_valid_after = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    checks++; if (out_data !== '0)     begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if ({out_passes, out_sat, out_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b want=0000", {out_passes, out_sat, out_err}); end
    checks++; if (shl_shift !== 3'd0)  begin errors++; $display("FAIL reset_shl_shift got=%0d want=0", shl_shift); end
    rst = 1'b0;
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL release_in_ready_early got=%0b want=0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_zero_lanes();
    logic [95:0] d = 96'h0123456789AB0123456789AB;
    run_word(d, 4'd0, 12'hFFF, 0);
    checks++; if (obs_timeout)        begin errors++; $display("FAIL zero_timeout got=1 want=0"); end
    checks++; if (obs_data !== d)     begin errors++; $display("FAIL zero_data got=%h want=%h", obs_data, d); end
    checks++; if (obs_passes != 0)    begin errors++; $display("FAIL zero_passes got=%0d want=0", obs_passes); end
    checks++; if (obs_lat != 1)       begin errors++; $display("FAIL zero_latency got=%0d want=1", obs_lat); end
    checks++; if (obs_steps != 0)     begin errors++; $display("FAIL zero_steps got=%h want=0", obs_steps); end
  endtask

  task automatic test_three_lanes();
    logic [95:0] d;
    logic [95:0] exp;
    for (int i = 0; i < 8; i++) d[i*12 +: 12] = 12'(i);
    exp = {12'h004, 12'h003, 12'h002, 12'h001, 12'h000, 12'hABC, 12'hABC, 12'hABC};
    run_word(d, 4'd3, 12'hABC, 0);
    checks++; if (obs_data !== exp)   begin errors++; $display("FAIL three_data got=%h want=%h", obs_data, exp); end
    checks++; if (obs_steps != 3)     begin errors++; $display("FAIL three_steps got=%h want=3", obs_steps); end
    checks++; if (obs_passes != 1)    begin errors++; $display("FAIL three_passes got=%0d want=1", obs_passes); end
    checks++; if (obs_lat != 2)       begin errors++; $display("FAIL three_latency got=%0d want=2", obs_lat); end
  endtask

  task automatic test_seven_lanes();
    logic [95:0] d = {$urandom, $urandom, $urandom};
    logic [95:0] exp = {d[11:0], {7{12'h3C6}}};
    run_word(d, 4'd7, 12'h3C6, 0);
    checks++; if (obs_data !== exp)   begin errors++; $display("FAIL seven_data got=%h want=%h", obs_data, exp); end
    checks++; if (obs_steps != 'h52)  begin errors++; $display("FAIL seven_steps got=%h want=52", obs_steps); end
    checks++; if (obs_passes != 2)    begin errors++; $display("FAIL seven_passes got=%0d want=2", obs_passes); end
    checks++; if (obs_lat != 3)       begin errors++; $display("FAIL seven_latency got=%0d want=3", obs_lat); end
  endtask

  task automatic test_saturate();
    logic [95:0] d = {$urandom, $urandom, $urandom};
    run_word(d, 4'd12, 12'h5A5, 0);
    checks++; if (obs_sat !== 1'b1)            begin errors++; $display("FAIL sat_flag got=%0b want=1", obs_sat); end
    checks++; if (obs_data !== {8{12'h5A5}})   begin errors++; $display("FAIL sat_data got=%h want=all 5a5", obs_data); end
    checks++; if (obs_steps != 'h53)           begin errors++; $display("FAIL sat_steps got=%h want=53", obs_steps); end
    checks++; if (obs_lat != 3)                begin errors++; $display("FAIL sat_latency got=%0d want=3", obs_lat); end
  endtask

  task automatic test_backpressure();
    logic [95:0] d = {$urandom, $urandom, $urandom};
    run_word(d, 4'd2, 12'h111, 4);
    checks++; if (!obs_stable)                 begin errors++; $display("FAIL hold_stable got=0 want=1"); end
    checks++; if (obs_data !== ref_shift(d, 2, 12'h111)) begin errors++; $display("FAIL hold_data got=%h want=%h", obs_data, ref_shift(d, 2, 12'h111)); end
    checks++; if (obs_ready_after !== 1'b1)    begin errors++; $display("FAIL hold_ready_after got=%0b want=1", obs_ready_after); end
    checks++; if (obs_valid_after !== 1'b0)    begin errors++; $display("FAIL hold_valid_after got=%0b want=0", obs_valid_after); end
  endtask

  task automatic test_reset_mid_step();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom};
    in_lanes = 4'd7;
    in_fill  = 12'h777;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (shl_shift !== 3'd5) begin errors++; $display("FAIL midrst_in_step got=%0d want=5", shl_shift); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_immediate got=%0b%0b want=00", out_valid, in_ready); end
    checks++; if (out_data !== '0 || shl_shift !== 3'd0)    begin errors++; $display("FAIL midrst_regs got=%h/%0d want=0/0", out_data, shl_shift); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_ready got=%0b want=1", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output got=%0b want=0", out_valid); end
  endtask

`ifdef SHL_SEQ_ERRCHK_EN
  task automatic test_errchk();
    logic [95:0] d = {$urandom, $urandom, $urandom};
    force_bad = 1'b1;
    run_word(d, 4'd7, 12'h0F0, 0);
    force_bad = 1'b0;
    checks++; if (obs_err !== 1'b1)   begin errors++; $display("FAIL errchk_flag got=%0b want=1", obs_err); end
    checks++; if (obs_passes != 0)    begin errors++; $display("FAIL errchk_passes got=%0d want=0", obs_passes); end
    checks++; if (obs_data !== d)     begin errors++; $display("FAIL errchk_data got=%h want=%h", obs_data, d); end
    checks++; if (obs_lat != 2)       begin errors++; $display("FAIL errchk_latency got=%0d want=2", obs_lat); end
    run_word(d, 4'd1, 12'h0F0, 0);
    checks++; if (obs_err !== 1'b0)   begin errors++; $display("FAIL errchk_clear got=%0b want=0", obs_err); end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [95:0] d = {$urandom, $urandom, $urandom};
      logic [3:0]  l = 4'($urandom_range(0, 15));
      logic [11:0] f = 12'($urandom);
      int          n = ref_lanes(l);
      run_word(d, l, f, $urandom_range(0, 2));
      checks++; if (obs_timeout)                   begin errors++; $display("FAIL rnd%0d_timeout lanes=%0d", k, l); end
      checks++; if (obs_data !== ref_shift(d, n, f)) begin errors++; $display("FAIL rnd%0d_data lanes=%0d got=%h want=%h", k, l, obs_data, ref_shift(d, n, f)); end
      checks++; if (obs_passes != ref_passes(n))   begin errors++; $display("FAIL rnd%0d_passes got=%0d want=%0d", k, obs_passes, ref_passes(n)); end
      checks++; if (obs_sat !== (l > 4'd8))        begin errors++; $display("FAIL rnd%0d_sat got=%0b want=%0b", k, obs_sat, (l > 4'd8)); end
      checks++; if (obs_lat != ref_passes(n) + 1)  begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", k, obs_lat, ref_passes(n) + 1); end
      checks++; if (obs_steps != ref_steps(n))     begin errors++; $display("FAIL rnd%0d_steps got=%h want=%h", k, obs_steps, ref_steps(n)); end
      checks++; if (obs_err !== 1'b0)              begin errors++; $display("FAIL rnd%0d_err got=%0b want=0", k, obs_err); end
      checks++; if (!obs_stable || obs_ready_after !== 1'b1) begin errors++; $display("FAIL rnd%0d_handshake stable=%0b ready=%0b want=1/1", k, obs_stable, obs_ready_after); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_lanes();
    test_three_lanes();
    test_seven_lanes();
    test_saturate();
    test_backpressure();
    test_reset_mid_step();
`ifdef SHL_SEQ_ERRCHK_EN
    test_errchk();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
